// File: rtl/fpu_cpx_obuf_pkg.sv
// Shared definitions for the FPU-to-CPX output buffer: packet geometry and
// error flag positions.
package fpu_cpx_obuf_pkg;

  localparam int FPU_CPX_W       = 145;
  localparam int FPU_CPX_VLD_BIT = 144;

  localparam int OBUF_ERR_OVF = 0;
  localparam int OBUF_ERR_CRD = 1;

  typedef logic [FPU_CPX_W-1:0] cpx_pkt_t;

endpackage

// File: rtl/fpu_cpx_fifo.sv
// Generic synchronous FIFO with an empty-bypass read path: when empty, dout
// shows din so a same-cycle push can be popped immediately.
module fpu_cpx_fifo #(
  parameter  int WIDTH = 145,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      cnt
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign cnt   = cnt_q;
  assign dout  = empty ? din : mem_q[rd_ptr_q];

  // A bypassed packet is still written and read, so both pointers advance together.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && (!empty || push);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en && !rd_en)      cnt_d = cnt_q + CNT_ONE;
    else if (rd_en && !wr_en) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fpu_cpx_obuf.sv
// FPU result output buffer: queues valid packets and issues them to the CPX
// under a saturating credit counter, with a conservative stall to the arbiter.
module fpu_cpx_obuf
  import fpu_cpx_obuf_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int CREDITS = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic [FPU_CPX_W-1:0] fp_cpx_data_ca,
  input  logic                 cpx_fpu_grant,
  output logic                 fpu_cpx_req_cq,
  output logic [FPU_CPX_W-1:0] fpu_cpx_data_cq,
  output logic                 obuf_stall,
  output logic [AW:0]          obuf_cnt,
  output logic [1:0]           obuf_err
);

  localparam logic [2:0]    CRED_MAX = 3'(CREDITS);
  localparam logic [AW+1:0] STALL_TH = (AW+2)'(DEPTH - 1);

  logic       push, issue, credit_ok;
  logic       fifo_empty, fifo_full;
  logic       fifo_ovf, crd_ovf;
  cpx_pkt_t   fifo_dout;
  logic [2:0] credit_q, credit_d;
  logic       req_q;
  cpx_pkt_t   data_q;
  logic [1:0] err_q, err_d;

  assign push = fp_cpx_data_ca[FPU_CPX_VLD_BIT];

  fpu_cpx_fifo #(.WIDTH(FPU_CPX_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (rclk),
    .rst   (reset),
    .push  (push),
    .pop   (issue),
    .din   (fp_cpx_data_ca),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .cnt   (obuf_cnt)
  );

  // A grant arriving this cycle counts immediately, so a starved queue restarts at once.
  assign credit_ok = (credit_q != 3'd0) || cpx_fpu_grant;
  assign issue     = (!fifo_empty || push) && credit_ok;
  assign fifo_ovf  = push && fifo_full && !issue;

  always_comb begin
    credit_d = credit_q;
    crd_ovf  = 1'b0;
    if (issue && !cpx_fpu_grant) begin
      credit_d = credit_q - 3'd1;
    end else if (cpx_fpu_grant && !issue) begin
      if (credit_q == CRED_MAX) crd_ovf  = 1'b1;
      else                      credit_d = credit_q + 3'd1;
    end
    err_d = err_q;
    err_d[OBUF_ERR_OVF] = err_q[OBUF_ERR_OVF] | fifo_ovf;
    err_d[OBUF_ERR_CRD] = err_q[OBUF_ERR_CRD] | crd_ovf;
  end

  // Pops are ignored here; one slot is held back for the packet already in flight.
  assign obuf_stall = ({1'b0, obuf_cnt} + (AW+2)'(push)) >= STALL_TH;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (reset) begin
      credit_q <= CRED_MAX;
      req_q    <= 1'b0;
      data_q   <= '0;
      err_q    <= '0;
    end else begin
      credit_q <= credit_d;
      req_q    <= issue;
      err_q    <= err_d;
      if (issue) data_q <= fifo_dout;
    end
  end

  assign fpu_cpx_req_cq  = req_q;
  assign fpu_cpx_data_cq = data_q;
  assign obuf_err        = err_q;

endmodule

// File: tb/tb_fpu_cpx_obuf.sv
// Self-checking bench for fpu_cpx_obuf: directed scenarios with a packet
// scoreboard that checks every CPX request against arrival order.
module tb_fpu_cpx_obuf;
  import fpu_cpx_obuf_pkg::*;

  logic       rclk = 1'b0;
  logic       reset = 1'b1;
  cpx_pkt_t   data_ca = '0;
  logic       grant = 1'b0;
  logic       req_cq;
  cpx_pkt_t   data_cq;
  logic       stall;
  logic [2:0] cnt;
  logic [1:0] err;

  int n_checks = 0;
  int n_pass   = 0;
  cpx_pkt_t sbq[$];

  fpu_cpx_obuf #(.DEPTH(4), .CREDITS(2)) dut (
    .rclk            (rclk),
    .reset           (reset),
    .fp_cpx_data_ca  (data_ca),
    .cpx_fpu_grant   (grant),
    .fpu_cpx_req_cq  (req_cq),
    .fpu_cpx_data_cq (data_cq),
    .obuf_stall      (stall),
    .obuf_cnt        (cnt),
    .obuf_err        (err)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [144:0] act, input logic [144:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic cpx_pkt_t mk_pkt(input int id);
    return {1'b1, 16'(id), $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Every request must carry the oldest packet not yet delivered.
  always @(negedge rclk) begin
    if (req_cq === 1'b1) begin
      if (sbq.size() == 0) check("sb_unexpected_req", 1'b1, 1'b0);
      else check("sb_data_cq", data_cq, sbq.pop_front());
    end
  end

  task automatic cyc(input cpx_pkt_t d, input logic g, input logic keep);
    data_ca = d;
    grant   = g;
    if (d[144] && keep) sbq.push_back(d);
    @(posedge rclk);
    #1;
    data_ca = '0;
    grant   = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_ca = '0;
    grant   = 1'b0;
    @(posedge rclk);
    #1;
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic sb_drained(input string tag);
    @(negedge rclk);
    #1;
    check(tag, sbq.size(), 0);
  endtask

  initial begin
    cpx_pkt_t p1, p2;
    int       mcnt;
    logic     pend, pend_n;

    // 1: reset state and single-packet latency
    @(posedge rclk);
    do_reset();
    check("rst_req", req_cq, 1'b0);
    check("rst_data", data_cq, '0);
    check("rst_cnt", cnt, 3'd0);
    check("rst_err", err, 2'b00);
    check("rst_stall", stall, 1'b0);
    p1 = {1'b1, 144'h5A};
    cyc(p1, 1'b0, 1'b1);
    check("t1_req", req_cq, 1'b1);
    check("t1_data", data_cq, p1);
    check("t1_cnt", cnt, 3'd0);
    cyc(mk_pkt(11), 1'b0, 1'b1);
    check("t1_credit1_req", req_cq, 1'b1);
    cyc(mk_pkt(12), 1'b0, 1'b1);
    check("t1_credit0_req", req_cq, 1'b0);
    check("t1_credit0_cnt", cnt, 3'd1);

    // 2: back-to-back with two credits, then a grant releases the third
    do_reset();
    cyc(mk_pkt(21), 1'b0, 1'b1);
    check("t2_req_a", req_cq, 1'b1);
    p2 = mk_pkt(22);
    cyc(p2, 1'b0, 1'b1);
    check("t2_req_b", req_cq, 1'b1);
    cyc(mk_pkt(23), 1'b0, 1'b1);
    check("t2_req_c", req_cq, 1'b0);
    check("t2_cnt_c", cnt, 3'd1);
    check("t2_data_hold", data_cq, p2);
    cyc('0, 1'b0, 1'b0);
    check("t2_idle_req", req_cq, 1'b0);
    check("t2_idle_cnt", cnt, 3'd1);
    cyc('0, 1'b1, 1'b0);
    check("t2_grant_req", req_cq, 1'b1);
    check("t2_grant_cnt", cnt, 3'd0);
    sb_drained("t2_sb_empty");

    // 3: stall with zero credit and an arbiter that honours it
    mcnt = 0;
    pend = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_ca = pend ? mk_pkt(300 + i) : '0;
      if (pend) sbq.push_back(data_ca);
      #1;
      check("t3_stall", stall, (mcnt + int'(pend)) >= 3);
      pend_n = !stall;
      @(posedge rclk);
      #1;
      mcnt += int'(pend);
      pend = pend_n;
      data_ca = '0;
      check("t3_cnt", cnt, 3'(mcnt));
      check("t3_req", req_cq, 1'b0);
    end
    check("t3_err", err, 2'b00);

    // 4: overflow drops the packet and leaves queued data intact
    cyc(mk_pkt(40), 1'b0, 1'b1);
    check("t4_full_cnt", cnt, 3'd4);
    check("t4_full_stall", stall, 1'b1);
    cyc(mk_pkt(41), 1'b0, 1'b0);
    check("t4_drop_cnt", cnt, 3'd4);
    check("t4_drop_err", err, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cyc('0, 1'b1, 1'b0);
      check("t4_drain_req", req_cq, 1'b1);
    end
    check("t4_drain_cnt", cnt, 3'd0);
    check("t4_err_sticky", err, 2'b01);
    sb_drained("t4_sb_empty");

    // 5: grant with issue holds credit; grant at full credit flags an error
    do_reset();
    cyc(mk_pkt(50), 1'b0, 1'b1);
    cyc(mk_pkt(51), 1'b1, 1'b1);
    check("t5_gi_req", req_cq, 1'b1);
    cyc(mk_pkt(52), 1'b0, 1'b1);
    check("t5_c1_req", req_cq, 1'b1);
    cyc(mk_pkt(53), 1'b0, 1'b1);
    check("t5_c0_req", req_cq, 1'b0);
    check("t5_c0_cnt", cnt, 3'd1);
    cyc('0, 1'b1, 1'b0);
    check("t5_g0_req", req_cq, 1'b1);
    cyc('0, 1'b1, 1'b0);
    check("t5_g1_req", req_cq, 1'b0);
    cyc('0, 1'b1, 1'b0);
    check("t5_g2_err", err, 2'b00);
    cyc('0, 1'b1, 1'b0);
    check("t5_crd_ovf_err", err, 2'b10);
    cyc(mk_pkt(54), 1'b0, 1'b1);
    check("t5_sat_req_a", req_cq, 1'b1);
    cyc(mk_pkt(55), 1'b0, 1'b1);
    check("t5_sat_req_b", req_cq, 1'b1);
    cyc(mk_pkt(56), 1'b0, 1'b1);
    check("t5_sat_req_c", req_cq, 1'b0);
    check("t5_sat_cnt", cnt, 3'd1);

    // 6: reset discards queued and in-flight packets
    cyc(mk_pkt(60), 1'b0, 1'b1);
    cyc(mk_pkt(61), 1'b0, 1'b1);
    check("t6_pre_cnt", cnt, 3'd3);
    cyc(mk_pkt(62), 1'b1, 1'b1);
    check("t6_pre_req", req_cq, 1'b1);
    check("t6_pre_cnt2", cnt, 3'd3);
    reset = 1'b1;
    cyc(mk_pkt(63), 1'b1, 1'b0);
    reset = 1'b0;
    sbq.delete();
    check("t6_rst_cnt", cnt, 3'd0);
    check("t6_rst_req", req_cq, 1'b0);
    check("t6_rst_err", err, 2'b00);
    check("t6_rst_data", data_cq, '0);
    cyc(mk_pkt(64), 1'b0, 1'b1);
    check("t6_crd_req_a", req_cq, 1'b1);
    cyc(mk_pkt(65), 1'b0, 1'b1);
    check("t6_crd_req_b", req_cq, 1'b1);
    cyc(mk_pkt(66), 1'b0, 1'b1);
    check("t6_crd_req_c", req_cq, 1'b0);
    cyc('0, 1'b1, 1'b0);
    sb_drained("t6_sb_empty");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
